illop_trap_seq: RTL and testbench

ILLOP_TRAP_SEQ -- requirements
Module: illop_trap_seq

---
 rtl/illop_trap_seq.sv | 110 +++++++++++
 tb/tb_illop_trap_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/illop_trap_seq.sv
// illop_trap_seq: stage-1 instruction register with illegal-opcode trap sequencing.
// A word sits in stage 1 while an external decoder judges cpipe1s. Legal words
// go on to stage 2. An illegal word is captured into trap_opc, fetch is flushed,
// and the block waits for the exception unit's acknowledge. It then stays idle
// for TRAP_HOLDOFF cycles before it accepts new words again.
module illop_trap_seq #(
  parameter int TRAP_HOLDOFF = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_opc,
  output logic [9:0]       cpipe1s,
  input  logic             pillegalopc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_opc,
  output logic             trap_req,
  input  logic             trap_ack,
  output logic [9:0]       trap_opc,
  output logic             flush,
  output logic [CNT_W-1:0] trap_count
);

  // Countdown is at least one bit wide so that TRAP_HOLDOFF = 0 still elaborates.
  localparam int CD_W = (TRAP_HOLDOFF > 0) ? $clog2(TRAP_HOLDOFF + 1) : 1;
  localparam logic [CD_W-1:0]  HOLD_INIT = CD_W'(TRAP_HOLDOFF);
  localparam logic [CD_W-1:0]  HOLD_LAST = CD_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    RUN,
    TRAP,
    HOLD
  } state_t;

  state_t          state;
  logic            s1_valid;
  logic [9:0]      s1_opc;
  logic [CD_W-1:0] countdown;

  assign cpipe1s  = s1_valid ? s1_opc : 10'h000;
  assign out_opc  = s1_opc;
  assign trap_req = (state == TRAP);

  // Handshake qualifiers: words move only in RUN, and an illegal word never reaches stage 2.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (state == RUN) begin
      in_ready  = ~s1_valid | (out_ready & ~pillegalopc);
      out_valid = s1_valid & ~pillegalopc;
    end
  end

  // Sequencer: stage-1 loading, trap capture, acknowledge wait and holdoff countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      s1_valid   <= 1'b0;
      s1_opc     <= 10'h000;
      trap_opc   <= 10'h000;
      flush      <= 1'b0;
      trap_count <= '0;
      countdown  <= '0;
    end else begin
      flush <= 1'b0;
      case (state)
        RUN: begin
          if (s1_valid && pillegalopc) begin
            trap_opc <= s1_opc;
            s1_valid <= 1'b0;
            flush    <= 1'b1;
            if (trap_count != CNT_MAX) begin
              trap_count <= trap_count + 1'b1;
            end
            state <= TRAP;
          end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
              s1_opc <= in_opc;
            end
          end
        end
        TRAP: begin
          if (trap_ack) begin
            if (TRAP_HOLDOFF == 0) begin
              state <= RUN;
            end else begin
              countdown <= HOLD_INIT;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          countdown <= countdown - 1'b1;
          if (countdown <= HOLD_LAST) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_illop_trap_seq.sv
// tb_illop_trap_seq: directed vectors for illop_trap_seq with hand-computed expectations.
// The bench supplies its own illegal-opcode decoder. A word is illegal when bit 9
// is set, or when bit 7 is set while bit 5 is clear. Under this rule 0x200 and
// 0x080 are illegal, and 0x0A0 and 0x000 are legal.
module tb_illop_trap_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_opc;
  logic [9:0] cpipe1s;
  logic       pillegalopc;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_opc;
  logic       trap_req;
  logic       trap_ack;
  logic [9:0] trap_opc;
  logic       flush;
  logic [1:0] trap_count;

  int vec_count  = 0;
  int miscompare = 0;

  illop_trap_seq #(
    .TRAP_HOLDOFF(4),
    .CNT_W       (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opc     (in_opc),
    .cpipe1s    (cpipe1s),
    .pillegalopc(pillegalopc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opc    (out_opc),
    .trap_req   (trap_req),
    .trap_ack   (trap_ack),
    .trap_opc   (trap_opc),
    .flush      (flush),
    .trap_count (trap_count)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Decoder model: combinational verdict on the stage-1 control field.
  assign pillegalopc = cpipe1s[9] | (cpipe1s[7] & ~cpipe1s[5]);

  task automatic applyStimulus(input logic v, input logic [9:0] opc,
                               input logic ordy, input logic ack);
    in_valid  = v;
    in_opc    = opc;
    out_ready = ordy;
    trap_ack  = ack;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompare++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    step();
    step();
    checkOutput("rst_trap_req",   32'(trap_req),   32'h0);
    checkOutput("rst_cpipe1s",    32'(cpipe1s),    32'h0);
    checkOutput("rst_out_valid",  32'(out_valid),  32'h0);
    checkOutput("rst_out_opc",    32'(out_opc),    32'h0);
    checkOutput("rst_trap_opc",   32'(trap_opc),   32'h0);
    checkOutput("rst_flush",      32'(flush),      32'h0);
    checkOutput("rst_trap_count", 32'(trap_count), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("rel_in_ready", 32'(in_ready), 32'h1);

    // Legal stream of three words back to back at full rate.
    applyStimulus(1'b1, 10'h0A0, 1'b1, 1'b0);
    step();
    checkOutput("leg0_valid", 32'(out_valid), 32'h1);
    checkOutput("leg0_opc",   32'(out_opc),   32'h0A0);
    checkOutput("leg0_ready", 32'(in_ready),  32'h1);
    checkOutput("leg0_trap",  32'(trap_req),  32'h0);
    applyStimulus(1'b1, 10'h000, 1'b1, 1'b0);
    step();
    checkOutput("leg1_valid", 32'(out_valid), 32'h1);
    checkOutput("leg1_opc",   32'(out_opc),   32'h000);
    checkOutput("leg1_trap",  32'(trap_req),  32'h0);
    applyStimulus(1'b1, 10'h0A0, 1'b1, 1'b0);
    step();
    checkOutput("leg2_valid", 32'(out_valid), 32'h1);
    checkOutput("leg2_opc",   32'(out_opc),   32'h0A0);
    checkOutput("leg2_trap",  32'(trap_req),  32'h0);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    step();
    checkOutput("leg_drain_valid", 32'(out_valid), 32'h0);
    checkOutput("leg_drain_trap",  32'(trap_req),  32'h0);

    // An acknowledge outside TRAP has no effect.
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b1);
    step();
    checkOutput("stray_ack_trap",  32'(trap_req), 32'h0);
    checkOutput("stray_ack_ready", 32'(in_ready), 32'h1);

    // A bit-9 illegal word is held back from stage 2 and trapped.
    applyStimulus(1'b1, 10'h200, 1'b1, 1'b0);
    step();
    checkOutput("ill_cpipe1s",   32'(cpipe1s),   32'h200);
    checkOutput("ill_out_valid", 32'(out_valid), 32'h0);
    checkOutput("ill_in_ready",  32'(in_ready),  32'h0);
    checkOutput("ill_pre_flush", 32'(flush),     32'h0);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    step();
    checkOutput("cap_flush",     32'(flush),      32'h1);
    checkOutput("cap_trap_req",  32'(trap_req),   32'h1);
    checkOutput("cap_trap_opc",  32'(trap_opc),   32'h200);
    checkOutput("cap_count",     32'(trap_count), 32'h1);
    checkOutput("cap_out_valid", 32'(out_valid),  32'h0);
    checkOutput("cap_cpipe1s",   32'(cpipe1s),    32'h0);
    step();
    checkOutput("flush_one_cycle", 32'(flush), 32'h0);

    // The acknowledge is held low for ten cycles. After it is seen, four holdoff cycles follow.
    for (int i = 0; i < 10; i++) begin
      checkOutput("wait_trap_req", 32'(trap_req), 32'h1);
      checkOutput("wait_in_ready", 32'(in_ready), 32'h0);
      if (i == 9) applyStimulus(1'b0, 10'h000, 1'b1, 1'b1);
      step();
    end
    applyStimulus(1'b1, 10'h0A0, 1'b1, 1'b0);
    checkOutput("ack_trap_req", 32'(trap_req), 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("hold_in_ready",  32'(in_ready),  32'h0);
      checkOutput("hold_out_valid", 32'(out_valid), 32'h0);
      step();
    end
    checkOutput("resume_in_ready",  32'(in_ready),  32'h1);
    checkOutput("resume_not_taken", 32'(out_valid), 32'h0);
    checkOutput("trap_opc_held",    32'(trap_opc),  32'h200);

    // Backpressure: the word stays in stage 1 and the next fetch word must wait.
    applyStimulus(1'b1, 10'h0A0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 10'h000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_valid", 32'(out_valid), 32'h1);
      checkOutput("bp_out_opc",   32'(out_opc),   32'h0A0);
      checkOutput("bp_in_ready",  32'(in_ready),  32'h0);
      step();
    end
    applyStimulus(1'b1, 10'h000, 1'b1, 1'b0);
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'h1);
    step();
    checkOutput("bp_next_valid", 32'(out_valid), 32'h1);
    checkOutput("bp_next_opc",   32'(out_opc),   32'h000);
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    step();
    checkOutput("bp_drain_valid", 32'(out_valid), 32'h0);

    // Saturation: four 0x080 traps with the 2-bit counter should read 1, 2, 3, 3.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 10'h080, 1'b0, 1'b0);
      step();
      checkOutput("sat_out_valid", 32'(out_valid), 32'h0);
      applyStimulus(1'b0, 10'h000, 1'b0, 1'b0);
      step();
      checkOutput("sat_count",    32'(trap_count), (k < 3) ? 32'(k + 1) : 32'h3);
      checkOutput("sat_trap_opc", 32'(trap_opc),   32'h080);
      applyStimulus(1'b0, 10'h000, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step();
      checkOutput("sat_resume", 32'(in_ready), 32'h1);
    end

    // Reset while a trap is pending clears it at once. No acknowledge and no flush follow.
    applyStimulus(1'b1, 10'h200, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 10'h000, 1'b1, 1'b0);
    step();
    step();
    checkOutput("mid_trap_req", 32'(trap_req), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_trap_req", 32'(trap_req),   32'h0);
    checkOutput("mid_rst_count",    32'(trap_count), 32'h0);
    checkOutput("mid_rst_opc",      32'(trap_opc),   32'h0);
    checkOutput("mid_rst_flush",    32'(flush),      32'h0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_rel_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("mid_no_flush",  32'(flush),    32'h0);
      checkOutput("mid_no_trap",   32'(trap_req), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
    $finish;
  end

endmodule
